// File: rtl/sccb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sccb_pkg
// Shared definitions for the SCCB register-access arbiter:
//   - OCP-style command codes (MCMD_*) and response codes (SRESP_*)
//   - arbiter state encoding (arb_state_e)
//   - requester port selection (port_sel_t, PORT_A / PORT_B)
// ---------------------------------------------------------------------------
package sccb_pkg;

    localparam logic [2:0] MCMD_IDLE = 3'b000;
    localparam logic [2:0] MCMD_WR   = 3'b001;
    localparam logic [2:0] MCMD_RD   = 3'b010;

    localparam logic [1:0] SRESP_NULL = 2'b00;
    localparam logic [1:0] SRESP_DVA  = 2'b01;
    localparam logic [1:0] SRESP_ERR  = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef logic port_sel_t;

    localparam port_sel_t PORT_A = 1'b0;
    localparam port_sel_t PORT_B = 1'b1;

endpackage

// File: rtl/sccb_arbiter_if.sv
// ---------------------------------------------------------------------------
// sccb_arbiter_if
// Bundles the two requester ports (A: boot config sequencer, B: runtime
// host/debug access) and the single SCCB master-core port.
//   x_mcmd/x_maddr/x_mdata        : requester command, {dev id, reg}, wdata
//   x_scmdaccept/x_sresp/x_sdata  : accept pulse, response, read data
//   m_*                           : the same signals towards the master core
// Modports:
//   slave  - the arbiter's view (requests in, master commands out)
//   master - the surrounding system's view (opposite directions)
// ---------------------------------------------------------------------------
interface sccb_arbiter_if;

    logic [2:0]  a_mcmd;
    logic [14:0] a_maddr;
    logic [7:0]  a_mdata;
    logic        a_scmdaccept;
    logic [1:0]  a_sresp;
    logic [7:0]  a_sdata;

    logic [2:0]  b_mcmd;
    logic [14:0] b_maddr;
    logic [7:0]  b_mdata;
    logic        b_scmdaccept;
    logic [1:0]  b_sresp;
    logic [7:0]  b_sdata;

    logic [2:0]  m_mcmd;
    logic [14:0] m_maddr;
    logic [7:0]  m_mdata;
    logic        m_scmdaccept;
    logic [1:0]  m_sresp;
    logic [7:0]  m_sdata;

    modport slave (
        input  a_mcmd, a_maddr, a_mdata,
        output a_scmdaccept, a_sresp, a_sdata,
        input  b_mcmd, b_maddr, b_mdata,
        output b_scmdaccept, b_sresp, b_sdata,
        output m_mcmd, m_maddr, m_mdata,
        input  m_scmdaccept, m_sresp, m_sdata
    );

    modport master (
        output a_mcmd, a_maddr, a_mdata,
        input  a_scmdaccept, a_sresp, a_sdata,
        output b_mcmd, b_maddr, b_mdata,
        input  b_scmdaccept, b_sresp, b_sdata,
        input  m_mcmd, m_maddr, m_mdata,
        output m_scmdaccept, m_sresp, m_sdata
    );

endinterface

// File: rtl/sccb_rr_pick.sv
// ---------------------------------------------------------------------------
// sccb_rr_pick
// Combinational two-way picker.
//   req_a, req_b  : pending requests
//   last_grant    : port that owned the previous transaction
//   round_robin   : 1 = alternate on contention, 0 = port A always wins
//   grant_valid   : at least one request pending
//   grant_sel     : selected port (meaningful when grant_valid)
// ---------------------------------------------------------------------------
module sccb_rr_pick
    import sccb_pkg::*;
(
    input  logic      req_a,
    input  logic      req_b,
    input  port_sel_t last_grant,
    input  logic      round_robin,
    output logic      grant_valid,
    output port_sel_t grant_sel
);

    // A lone request always wins; on contention the port that did not own
    // the last transaction gets the slot in round-robin mode.
    always_comb begin
        grant_valid = req_a | req_b;
        grant_sel   = PORT_A;
        if (req_a && req_b) begin
            grant_sel = round_robin ? ~last_grant : PORT_A;
        end else if (req_b) begin
            grant_sel = PORT_B;
        end
    end

endmodule

// File: rtl/sccb_arbiter.sv
// ---------------------------------------------------------------------------
// sccb_arbiter
// Shares one SCCB register-access master core between two requesters,
// keeping exactly one command outstanding and routing the response back
// to the port that issued it.
// Ports:
//   config_clk    : clock
//   config_reset  : synchronous active-high reset
//   bus           : sccb_arbiter_if.slave (requester A/B and master-core signals)
//   busy          : high whenever the arbiter is not IDLE
//   timeout_flag  : sticky watchdog flag (only with SCCB_ARB_TIMEOUT_EN)
// Parameters:
//   ROUND_ROBIN    : 1 = alternate grants on contention, 0 = port A wins
//   TIMEOUT_CYCLES : watchdog limit (only with SCCB_ARB_TIMEOUT_EN)
// Optional build macro SCCB_ARB_TIMEOUT_EN adds a watchdog that answers the
// owner with ERR when the master core stalls in ISSUE/WAIT.
// ---------------------------------------------------------------------------
module sccb_arbiter
    import sccb_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
`ifdef SCCB_ARB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic          config_clk,
    input  logic          config_reset,
    sccb_arbiter_if.slave bus,
    output logic          busy
`ifdef SCCB_ARB_TIMEOUT_EN
    , output logic        timeout_flag
`endif
);

    arb_state_e  state_q, state_d;
    port_sel_t   owner_q, owner_d;
    port_sel_t   lastGrant_q, lastGrant_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [1:0]  resp_q, resp_d;
    logic        accept_q, accept_d;

    logic        grantValid;
    port_sel_t   grantSel;
    logic [7:0]  masterData;

`ifdef SCCB_ARB_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wdog_q, wdog_d;
    logic        flag_q, flag_d;
`endif

    sccb_rr_pick u_pick (
        .req_a       (bus.a_mcmd != MCMD_IDLE),
        .req_b       (bus.b_mcmd != MCMD_IDLE),
        .last_grant  (lastGrant_q),
        .round_robin (ROUND_ROBIN),
        .grant_valid (grantValid),
        .grant_sel   (grantSel)
    );

    // Writes carry no read data back, so their response data is forced to
    // zero whatever the master core happens to drive.
    assign masterData = (cmd_q == MCMD_WR) ? 8'h00 : bus.m_sdata;

    // Next-state logic: grant and latch in IDLE, hold the command in ISSUE
    // until the core accepts, wait for DVA, then present one response cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        accept_d    = 1'b0;
`ifdef SCCB_ARB_TIMEOUT_EN
        wdog_d      = wdog_q;
        flag_d      = flag_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (grantValid) begin
                    state_d  = ARB_ISSUE;
                    owner_d  = grantSel;
                    accept_d = 1'b1;
                    cmd_d    = (grantSel == PORT_A) ? bus.a_mcmd  : bus.b_mcmd;
                    addr_d   = (grantSel == PORT_A) ? bus.a_maddr : bus.b_maddr;
                    data_d   = (grantSel == PORT_A) ? bus.a_mdata : bus.b_mdata;
`ifdef SCCB_ARB_TIMEOUT_EN
                    wdog_d   = 16'd0;
`endif
                end
            end
            ARB_ISSUE: begin
                if (bus.m_scmdaccept) begin
                    if (bus.m_sresp == SRESP_DVA) begin
                        state_d = ARB_RESP;
                        rdata_d = masterData;
                        resp_d  = SRESP_DVA;
                    end else begin
                        state_d = ARB_WAIT;
                    end
                end
            end
            ARB_WAIT: begin
                if (bus.m_sresp == SRESP_DVA) begin
                    state_d = ARB_RESP;
                    rdata_d = masterData;
                    resp_d  = SRESP_DVA;
                end
            end
            ARB_RESP: begin
                state_d     = ARB_IDLE;
                lastGrant_d = owner_q;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
`ifdef SCCB_ARB_TIMEOUT_EN
        // A genuine response in the same cycle as the limit takes precedence.
        if ((state_q == ARB_ISSUE || state_q == ARB_WAIT) && state_d != ARB_RESP) begin
            if (wdog_q == WDOG_LAST) begin
                state_d = ARB_RESP;
                resp_d  = SRESP_ERR;
                rdata_d = 8'h00;
                flag_d  = 1'b1;
            end else begin
                wdog_d = wdog_q + 16'd1;
            end
        end
`endif
    end

    // State and holding registers. last_grant resets to B so that port A
    // wins the very first contention.
    always_ff @(posedge config_clk) begin
        if (config_reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= PORT_A;
            lastGrant_q <= PORT_B;
            cmd_q       <= MCMD_IDLE;
            addr_q      <= 15'h0000;
            data_q      <= 8'h00;
            rdata_q     <= 8'h00;
            resp_q      <= SRESP_NULL;
            accept_q    <= 1'b0;
`ifdef SCCB_ARB_TIMEOUT_EN
            wdog_q      <= 16'd0;
            flag_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            accept_q    <= accept_d;
`ifdef SCCB_ARB_TIMEOUT_EN
            wdog_q      <= wdog_d;
            flag_q      <= flag_d;
`endif
        end
    end

    // Outputs come straight from registers; the non-owner port always
    // reads zero, and the master sees a command only while in ISSUE.
    always_comb begin
        bus.m_mcmd       = (state_q == ARB_ISSUE) ? cmd_q  : MCMD_IDLE;
        bus.m_maddr      = (state_q == ARB_ISSUE) ? addr_q : 15'h0000;
        bus.m_mdata      = (state_q == ARB_ISSUE) ? data_q : 8'h00;
        bus.a_scmdaccept = accept_q && (owner_q == PORT_A);
        bus.b_scmdaccept = accept_q && (owner_q == PORT_B);
        bus.a_sresp      = (state_q == ARB_RESP && owner_q == PORT_A) ? resp_q  : SRESP_NULL;
        bus.b_sresp      = (state_q == ARB_RESP && owner_q == PORT_B) ? resp_q  : SRESP_NULL;
        bus.a_sdata      = (state_q == ARB_RESP && owner_q == PORT_A) ? rdata_q : 8'h00;
        bus.b_sdata      = (state_q == ARB_RESP && owner_q == PORT_B) ? rdata_q : 8'h00;
        busy             = (state_q != ARB_IDLE);
    end

`ifdef SCCB_ARB_TIMEOUT_EN
    assign timeout_flag = flag_q;
`endif

endmodule

// File: tb/tb_sccb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sccb_arbiter
// Directed bench for sccb_arbiter: a round-robin instance driven by a
// configurable master-core model, plus a fixed-priority instance whose
// master core accepts and answers immediately.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sccb_arbiter;
    import sccb_pkg::*;

    logic config_clk = 1'b0;
    logic config_reset;
    logic busy;
    logic busyFp;
`ifdef SCCB_ARB_TIMEOUT_EN
    logic timeoutFlag;
    logic timeoutFlagFp;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    int         acceptDelay  = 0;
    int         respDelay    = 0;
    logic [7:0] respData     = 8'h00;
    bit         neverRespond = 1'b0;

    sccb_arbiter_if bus();
    sccb_arbiter_if busFp();

    always #5 config_clk = ~config_clk;

    sccb_arbiter #(
        .ROUND_ROBIN    (1'b1)
`ifdef SCCB_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .config_clk   (config_clk),
        .config_reset (config_reset),
        .bus          (bus),
        .busy         (busy)
`ifdef SCCB_ARB_TIMEOUT_EN
        , .timeout_flag (timeoutFlag)
`endif
    );

    sccb_arbiter #(
        .ROUND_ROBIN    (1'b0)
`ifdef SCCB_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dutFp (
        .config_clk   (config_clk),
        .config_reset (config_reset),
        .bus          (busFp),
        .busy         (busyFp)
`ifdef SCCB_ARB_TIMEOUT_EN
        , .timeout_flag (timeoutFlagFp)
`endif
    );

    // Master-core model: accepts acceptDelay cycles after a command appears,
    // then answers DVA respDelay cycles after the accept (0 = same cycle).
    initial begin : masterModel
        int phase;
        int cnt;
        phase = 0;
        cnt   = 0;
        bus.m_scmdaccept = 1'b0;
        bus.m_sresp      = SRESP_NULL;
        bus.m_sdata      = 8'h00;
        forever begin
            @(posedge config_clk);
            #2;
            bus.m_scmdaccept = 1'b0;
            bus.m_sresp      = SRESP_NULL;
            bus.m_sdata      = 8'h00;
            if (config_reset) begin
                phase = 0;
                cnt   = 0;
            end else if (phase == 0) begin
                if (bus.m_mcmd != MCMD_IDLE) begin
                    if (cnt >= acceptDelay) begin
                        bus.m_scmdaccept = 1'b1;
                        cnt = 0;
                        if (!neverRespond && respDelay == 0) begin
                            bus.m_sresp = SRESP_DVA;
                            bus.m_sdata = respData;
                        end else begin
                            phase = 1;
                        end
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                cnt++;
                if (!neverRespond && cnt >= respDelay) begin
                    bus.m_sresp = SRESP_DVA;
                    bus.m_sdata = respData;
                    phase = 0;
                    cnt   = 0;
                end
            end
        end
    end

    initial begin : globalTimeout
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "[TB] aborted");
    end

    task automatic tick();
        @(posedge config_clk);
        #1;
    endtask

    task automatic test_reset();
        config_reset = 1'b1;
        repeat (3) tick();
        testsRun++;
        if (bus.m_mcmd !== MCMD_IDLE) begin
            testsFailed++;
            $display("[TB] FAIL reset_m_mcmd: got %b expected 000", bus.m_mcmd);
        end
        testsRun++;
        if ({bus.a_scmdaccept, bus.b_scmdaccept} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reset_scmdaccept: got %b expected 00", {bus.a_scmdaccept, bus.b_scmdaccept});
        end
        testsRun++;
        if ({bus.a_sresp, bus.b_sresp, bus.a_sdata, bus.b_sdata} !== 20'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_resp: got %h expected 00000", {bus.a_sresp, bus.b_sresp, bus.a_sdata, bus.b_sdata});
        end
        testsRun++;
        if ({busy, busyFp} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reset_busy: got %b expected 00", {busy, busyFp});
        end
        config_reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        int accCnt = 0, accCycle = -1, respCnt = 0, respCycle = -1, bActivity = 0;
        logic [2:0]  issueCmd = 3'bxxx, mcmdAfter = 3'bxxx;
        logic [14:0] issueAddr = 15'hx;
        logic [7:0]  issueData = 8'hxx, respSdata = 8'hxx;
        logic [1:0]  respCode = 2'bxx;
        acceptDelay  = 2;
        respDelay    = 5;
        respData     = 8'hEE;
        neverRespond = 1'b0;
        bus.a_mcmd  = MCMD_WR;
        bus.a_maddr = 15'h2112;
        bus.a_mdata = 8'h80;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            tick();
            if (bus.a_scmdaccept === 1'b1) begin
                accCnt++;
                accCycle  = cyc;
                issueCmd  = bus.m_mcmd;
                issueAddr = bus.m_maddr;
                issueData = bus.m_mdata;
                bus.a_mcmd = MCMD_IDLE;
            end
            if (bus.a_sresp !== SRESP_NULL) begin
                respCnt++;
                respCycle = cyc;
                respCode  = bus.a_sresp;
                respSdata = bus.a_sdata;
            end
            if (cyc == 4) mcmdAfter = bus.m_mcmd;
            if (bus.b_scmdaccept !== 1'b0 || bus.b_sresp !== 2'b00 || bus.b_sdata !== 8'h00) bActivity++;
        end
        testsRun++;
        if (accCnt != 1 || accCycle != 1) begin
            testsFailed++;
            $display("[TB] FAIL wr_accept: got count %0d cycle %0d expected count 1 cycle 1", accCnt, accCycle);
        end
        testsRun++;
        if (issueCmd !== MCMD_WR) begin
            testsFailed++;
            $display("[TB] FAIL wr_m_mcmd: got %b expected 001", issueCmd);
        end
        testsRun++;
        if (issueAddr !== 15'h2112 || issueData !== 8'h80) begin
            testsFailed++;
            $display("[TB] FAIL wr_m_addr_data: got %h/%h expected 2112/80", issueAddr, issueData);
        end
        testsRun++;
        if (mcmdAfter !== MCMD_IDLE) begin
            testsFailed++;
            $display("[TB] FAIL wr_mcmd_after_accept: got %b expected 000", mcmdAfter);
        end
        testsRun++;
        if (respCnt != 1 || respCycle != 9) begin
            testsFailed++;
            $display("[TB] FAIL wr_resp_timing: got count %0d cycle %0d expected count 1 cycle 9", respCnt, respCycle);
        end
        testsRun++;
        if (respCode !== SRESP_DVA || respSdata !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL wr_resp_value: got %b/%h expected 01/00", respCode, respSdata);
        end
        testsRun++;
        if (bActivity != 0) begin
            testsFailed++;
            $display("[TB] FAIL wr_port_b_quiet: got %0d active cycles expected 0", bActivity);
        end
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL wr_busy_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_read_b();
        int accCycle = -1, respCnt = 0, respCycle = -1, aActivity = 0;
        logic [14:0] issueAddr = 15'hx;
        logic [7:0]  respSdata = 8'hxx, sdataAfter = 8'hxx;
        acceptDelay = 0;
        respDelay   = 1;
        respData    = 8'h76;
        bus.b_mcmd  = MCMD_RD;
        bus.b_maddr = 15'h210A;
        bus.b_mdata = 8'h00;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (bus.b_scmdaccept === 1'b1) begin
                accCycle   = cyc;
                issueAddr  = bus.m_maddr;
                bus.b_mcmd = MCMD_IDLE;
            end
            if (bus.b_sresp === SRESP_DVA) begin
                respCnt++;
                respCycle = cyc;
                respSdata = bus.b_sdata;
            end
            if (cyc == 4) sdataAfter = bus.b_sdata;
            if (bus.a_scmdaccept !== 1'b0 || bus.a_sresp !== 2'b00 || bus.a_sdata !== 8'h00) aActivity++;
        end
        testsRun++;
        if (accCycle != 1 || issueAddr !== 15'h210A) begin
            testsFailed++;
            $display("[TB] FAIL rd_b_issue: got cycle %0d addr %h expected cycle 1 addr 210a", accCycle, issueAddr);
        end
        testsRun++;
        if (respCnt != 1 || respCycle != 3) begin
            testsFailed++;
            $display("[TB] FAIL rd_b_resp_timing: got count %0d cycle %0d expected count 1 cycle 3", respCnt, respCycle);
        end
        testsRun++;
        if (respSdata !== 8'h76 || sdataAfter !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL rd_b_sdata: got %h then %h expected 76 then 00", respSdata, sdataAfter);
        end
        testsRun++;
        if (aActivity != 0) begin
            testsFailed++;
            $display("[TB] FAIL rd_b_port_a_quiet: got %0d active cycles expected 0", aActivity);
        end
    endtask

    task automatic test_accept_with_resp();
        int accCycle = -1, respCycle = -1;
        logic [2:0] mcmdCyc2 = 3'bxxx;
        logic [7:0] respSdata = 8'hxx;
        acceptDelay = 1;
        respDelay   = 0;
        respData    = 8'h5A;
        bus.a_mcmd  = MCMD_RD;
        bus.a_maddr = 15'h0042;
        bus.a_mdata = 8'h00;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (bus.a_scmdaccept === 1'b1) begin
                accCycle   = cyc;
                bus.a_mcmd = MCMD_IDLE;
            end
            if (cyc == 2) mcmdCyc2 = bus.m_mcmd;
            if (bus.a_sresp === SRESP_DVA) begin
                respCycle = cyc;
                respSdata = bus.a_sdata;
            end
        end
        testsRun++;
        if (accCycle != 1 || mcmdCyc2 !== MCMD_RD) begin
            testsFailed++;
            $display("[TB] FAIL same_cycle_issue: got cycle %0d mcmd %b expected cycle 1 mcmd 010", accCycle, mcmdCyc2);
        end
        testsRun++;
        if (respCycle != 3 || respSdata !== 8'h5A) begin
            testsFailed++;
            $display("[TB] FAIL same_cycle_resp: got cycle %0d data %h expected cycle 3 data 5a", respCycle, respSdata);
        end
    endtask

    task automatic test_round_robin();
        port_sel_t order [4];
        int grants = 0, remA = 2, remB = 2, respA = 0, respB = 0;
        bit raiseA = 0, raiseB = 0;
        config_reset = 1'b1;
        repeat (2) tick();
        config_reset = 1'b0;
        acceptDelay = 0;
        respDelay   = 0;
        respData    = 8'h11;
        for (int i = 0; i < 4; i++) order[i] = PORT_A;
        bus.a_mcmd = MCMD_WR;
        bus.a_maddr = 15'h0101;
        bus.b_mcmd = MCMD_RD;
        bus.b_maddr = 15'h0202;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            tick();
            if (raiseA) begin bus.a_mcmd = MCMD_WR; raiseA = 0; end
            if (raiseB) begin bus.b_mcmd = MCMD_RD; raiseB = 0; end
            if (bus.a_scmdaccept === 1'b1) begin
                if (grants < 4) order[grants] = PORT_A;
                grants++;
                remA--;
                bus.a_mcmd = MCMD_IDLE;
                raiseA = (remA > 0);
            end
            if (bus.b_scmdaccept === 1'b1) begin
                if (grants < 4) order[grants] = PORT_B;
                grants++;
                remB--;
                bus.b_mcmd = MCMD_IDLE;
                raiseB = (remB > 0);
            end
            if (bus.a_sresp === SRESP_DVA) respA++;
            if (bus.b_sresp === SRESP_DVA) respB++;
        end
        testsRun++;
        if (grants != 4) begin
            testsFailed++;
            $display("[TB] FAIL rr_grant_count: got %0d expected 4", grants);
        end
        testsRun++;
        if ({order[0], order[1], order[2], order[3]} !== {PORT_A, PORT_B, PORT_A, PORT_B}) begin
            testsFailed++;
            $display("[TB] FAIL rr_order: got %b expected 0101 (0=A)", {order[0], order[1], order[2], order[3]});
        end
        testsRun++;
        if (respA != 2 || respB != 2) begin
            testsFailed++;
            $display("[TB] FAIL rr_resp_routing: got A %0d B %0d expected A 2 B 2", respA, respB);
        end
    endtask

    task automatic test_fixed_priority();
        port_sel_t order [4];
        int grants = 0, remA = 2, remB = 2;
        bit raiseA = 0, raiseB = 0;
        for (int i = 0; i < 4; i++) order[i] = PORT_B;
        busFp.a_mcmd = MCMD_WR;
        busFp.a_maddr = 15'h0303;
        busFp.b_mcmd = MCMD_RD;
        busFp.b_maddr = 15'h0404;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            tick();
            if (raiseA) begin busFp.a_mcmd = MCMD_WR; raiseA = 0; end
            if (raiseB) begin busFp.b_mcmd = MCMD_RD; raiseB = 0; end
            if (busFp.a_scmdaccept === 1'b1) begin
                if (grants < 4) order[grants] = PORT_A;
                grants++;
                remA--;
                busFp.a_mcmd = MCMD_IDLE;
                raiseA = (remA > 0);
            end
            if (busFp.b_scmdaccept === 1'b1) begin
                if (grants < 4) order[grants] = PORT_B;
                grants++;
                remB--;
                busFp.b_mcmd = MCMD_IDLE;
                raiseB = (remB > 0);
            end
        end
        testsRun++;
        if (grants != 4 || {order[0], order[1], order[2], order[3]} !== {PORT_A, PORT_A, PORT_B, PORT_B}) begin
            testsFailed++;
            $display("[TB] FAIL fp_order: got %0d grants order %b expected 4 grants order 0011 (0=A)",
                     grants, {order[0], order[1], order[2], order[3]});
        end
    endtask

    task automatic test_reset_mid();
        acceptDelay = 0;
        respDelay   = 10;
        respData    = 8'h3C;
        bus.a_mcmd  = MCMD_WR;
        bus.a_maddr = 15'h0777;
        bus.a_mdata = 8'h12;
        tick();
        bus.a_mcmd = MCMD_IDLE;
        tick();
        tick();
        testsRun++;
        if (busy !== 1'b1 || bus.m_mcmd !== MCMD_IDLE) begin
            testsFailed++;
            $display("[TB] FAIL mid_wait_state: got busy %b mcmd %b expected busy 1 mcmd 000", busy, bus.m_mcmd);
        end
        config_reset = 1'b1;
        tick();
        testsRun++;
        if ({busy, bus.m_mcmd, bus.a_scmdaccept, bus.a_sresp, bus.a_sdata} !== 15'h0) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_outputs: got busy %b mcmd %b acc %b resp %b sdata %h expected all 0",
                     busy, bus.m_mcmd, bus.a_scmdaccept, bus.a_sresp, bus.a_sdata);
        end
        config_reset = 1'b0;
        respDelay    = 0;
        bus.a_mcmd   = 3'b101;
        bus.a_maddr  = 15'h1234;
        bus.a_mdata  = 8'h55;
        tick();
        testsRun++;
        if (bus.a_scmdaccept !== 1'b1 || bus.m_mcmd !== 3'b101 || bus.m_maddr !== 15'h1234) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_grant: got acc %b mcmd %b addr %h expected acc 1 mcmd 101 addr 1234",
                     bus.a_scmdaccept, bus.m_mcmd, bus.m_maddr);
        end
        bus.a_mcmd = MCMD_IDLE;
        tick();
        testsRun++;
        if (bus.a_sresp !== SRESP_DVA || bus.a_sdata !== 8'h3C) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_resp: got %b/%h expected 01/3c", bus.a_sresp, bus.a_sdata);
        end
        tick();
        testsRun++;
        if (bus.a_sresp !== SRESP_NULL || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_idle: got resp %b busy %b expected 00 0", bus.a_sresp, busy);
        end
    endtask

`ifdef SCCB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int respCnt = 0, respCycle = -1;
        logic [1:0] respCode = 2'bxx;
        logic [7:0] respSdata = 8'hxx;
        logic [2:0] mcmdAtResp = 3'bxxx;
        config_reset = 1'b1;
        repeat (2) tick();
        config_reset = 1'b0;
        testsRun++;
        if (timeoutFlag !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL to_flag_initial: got %b expected 0", timeoutFlag);
        end
        acceptDelay  = 0;
        respData     = 8'h99;
        neverRespond = 1'b1;
        bus.a_mcmd   = MCMD_RD;
        bus.a_maddr  = 15'h0505;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            tick();
            if (bus.a_scmdaccept === 1'b1) bus.a_mcmd = MCMD_IDLE;
            if (bus.a_sresp !== SRESP_NULL) begin
                respCnt++;
                respCycle  = cyc;
                respCode   = bus.a_sresp;
                respSdata  = bus.a_sdata;
                mcmdAtResp = bus.m_mcmd;
            end
        end
        testsRun++;
        if (respCnt != 1 || respCycle != 17) begin
            testsFailed++;
            $display("[TB] FAIL to_resp_timing: got count %0d cycle %0d expected count 1 cycle 17", respCnt, respCycle);
        end
        testsRun++;
        if (respCode !== SRESP_ERR || respSdata !== 8'h00 || mcmdAtResp !== MCMD_IDLE) begin
            testsFailed++;
            $display("[TB] FAIL to_resp_value: got %b/%h mcmd %b expected 11/00 mcmd 000", respCode, respSdata, mcmdAtResp);
        end
        testsRun++;
        if (timeoutFlag !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL to_flag_sticky: got %b expected 1", timeoutFlag);
        end
        neverRespond = 1'b0;
        config_reset = 1'b1;
        tick();
        config_reset = 1'b0;
        tick();
        testsRun++;
        if (timeoutFlag !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL to_flag_cleared: got %b expected 0", timeoutFlag);
        end
    endtask
`endif

    initial begin
        config_reset = 1'b1;
        bus.a_mcmd   = MCMD_IDLE;
        bus.a_maddr  = 15'h0;
        bus.a_mdata  = 8'h0;
        bus.b_mcmd   = MCMD_IDLE;
        bus.b_maddr  = 15'h0;
        bus.b_mdata  = 8'h0;
        busFp.a_mcmd  = MCMD_IDLE;
        busFp.a_maddr = 15'h0;
        busFp.a_mdata = 8'h0;
        busFp.b_mcmd  = MCMD_IDLE;
        busFp.b_maddr = 15'h0;
        busFp.b_mdata = 8'h0;
        busFp.m_scmdaccept = 1'b1;
        busFp.m_sresp      = SRESP_DVA;
        busFp.m_sdata      = 8'h00;

        test_reset();
        test_single_write();
        test_read_b();
        test_accept_with_resp();
        test_round_robin();
        test_fixed_priority();
        test_reset_mid();
`ifdef SCCB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sccb_arbiter.md
Name: sccb_arbiter

Overview:
- Shares one SCCB register-access master (OCP-style mcmd/maddr/mdata in, scmdaccept/sresp/sdata out) between two requesters:
  - port A: boot-time config sequencer;
  - port B: runtime host/debug register access.
- Serialises transactions: exactly one outstanding command on the master side; the response is routed back to the owner.
- Sits between the requesters and the sccb master core in the config_clk domain.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate grants on contention; 0 = fixed priority, port A wins.
- TIMEOUT_CYCLES, 65535, watchdog limit in config_clk cycles (used only with SCCB_ARB_TIMEOUT_EN).

Ports:
- config_clk  in  1  clock
- config_reset  in  1  synchronous, active-high reset
- a_mcmd  in  3  port A command: 000 idle, 001 write, 010 read
- a_maddr  in  15  port A address {7-bit device id, 8-bit register}
- a_mdata  in  8  port A write data
- a_scmdaccept  out  1  port A command accepted (1-cycle pulse)
- a_sresp  out  2  port A response: 00 null, 01 DVA, 11 ERR
- a_sdata  out  8  port A read data, valid with a_sresp != 00
- b_mcmd, b_maddr, b_mdata, b_scmdaccept, b_sresp, b_sdata  as port A, for port B
- m_mcmd  out  3  command to sccb master
- m_maddr  out  15  address to master
- m_mdata  out  8  write data to master
- m_scmdaccept  in  1  master accepted command
- m_sresp  in  2  master response (01 = DVA)
- m_sdata  in  8  master read data
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, config_clk edge, config_reset=1):
  - state IDLE;
  - all outputs 0: m_mcmd=000, both scmdaccept=0, both sresp=00, both sdata=00, busy=0;
  - last_grant=B, so A wins the first contention;
  - reset asserted mid-transaction abandons it immediately; the master core shares the same reset.
- A request is pending when the port's mcmd != 000. Requester holds mcmd/maddr/mdata stable until its scmdaccept pulse, then drops mcmd the following cycle.
- States:
  - IDLE:
    - if any request is pending, pick the winner: one request wins; both pending → ROUND_ROBIN=1 grants the port not in last_grant, ROUND_ROBIN=0 grants A;
    - capture the winner's cmd/addr/data into holding registers;
    - register x_scmdaccept=1 for the winner (visible next cycle);
    - go ISSUE.
  - ISSUE:
    - drive m_* from holding registers; winner's scmdaccept is high for this first ISSUE cycle only;
    - remain while m_scmdaccept=0;
    - on m_scmdaccept=1: m_mcmd returns to 000 next cycle;
    - if m_sresp=01 in the same cycle, capture m_sdata and go RESP, else go WAIT.
  - WAIT:
    - m_mcmd=000;
    - on m_sresp=01, capture m_sdata and go RESP.
  - RESP:
    - owner's sresp=01 and sdata=captured for exactly one cycle; the other port reads 00;
    - update last_grant=owner;
    - go IDLE.
- Timing:
  - minimum latency from request sample to m_mcmd valid: 1 cycle;
  - minimum request-to-response: 3 cycles plus master latency;
  - no back-to-back grant: at least one IDLE cycle between transactions.
- Write responses return sdata=00.
- Stray m_sresp in IDLE/ISSUE-before-accept is ignored.
- Non-owner port sees scmdaccept=0 and sresp=00 throughout; its request stays pending.
- Invalid mcmd codes (011..111) are treated as pending, forwarded unchanged to the master, and sequenced identically.

Optional Feature:
- Macro: SCCB_ARB_TIMEOUT_EN.
- Defined:
  - a 16-bit watchdog clears on entering ISSUE and counts in ISSUE/WAIT;
  - on reaching TIMEOUT_CYCLES, go RESP with sresp=11 (ERR) and sdata=00 to the owner;
  - m_mcmd forced to 000;
  - adds status output timeout_flag (1 bit), sticky until reset.
- Undefined: no counter and no timeout_flag port; the arbiter waits indefinitely in ISSUE/WAIT.

Decomposition:
- Package sccb_pkg:
  - MCMD_IDLE/MCMD_WR/MCMD_RD;
  - SRESP_NULL/SRESP_DVA/SRESP_ERR;
  - arbiter state encoding (IDLE, ISSUE, WAIT, RESP);
  - port-select constants PORT_A/PORT_B.
- Sub-module sccb_rr_pick:
  - combinational two-way picker;
  - inputs: req_a, req_b, last_grant, round_robin;
  - outputs: grant_valid, grant_sel.

Test Plan:
- Single write on A (a_mcmd=001, a_maddr=0x2112, a_mdata=0x80); master accepts 2 cycles later and DVA follows 5 cycles later → m_maddr=0x2112, a_scmdaccept pulses once, a_sresp=01 for one cycle, b_* stay 0.
- Read on B (b_mcmd=010, b_maddr=0x210A); master returns m_sdata=0x76 with DVA → b_sresp=01, b_sdata=0x76 for exactly one cycle.
- A and B request in the same cycle with ROUND_ROBIN=1 → grant order A, B, A, B over 4 repeated requests; with ROUND_ROBIN=0 → A always first.
- m_scmdaccept and m_sresp=01 asserted in the same cycle → WAIT skipped, response reaches owner the next cycle.
- config_reset pulsed during WAIT → next cycle: all outputs 0, busy=0; a new A request is granted normally.
- With SCCB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, master never responds → owner sees sresp=11 after 16 cycles, timeout_flag=1, m_mcmd=000.
